// File: rtl/geno_load_scheduler.sv
// geno_load_scheduler: sequences one epistasis run of the SNP-pair engine.
// Loads the case and control genotype streams into the engine BRAMs by
// alternating priority, pulses eng_start, waits for eng_done and raises a
// sticky interrupt.
//
// Optional feature (macro GEN_EOP_CHECK_EN): when defined, err flags any
// transfer whose eop does not match "this is the stream's last beat".
// When undefined, the eop inputs are ignored and err is tied to 0.
//
// Handshake: a beat transfers on the rising edge where valid & ready are both
// high. ready depends only on registered state, never on valid, and at most
// one of q_ready / r_ready is high in any cycle.
module geno_load_scheduler #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  abort,
    input  logic                  irq_clear,
    input  logic [ADDR_WIDTH-1:0] case_beats,
    input  logic [ADDR_WIDTH-1:0] ctrl_beats,
    input  logic [DATA_WIDTH-1:0] q_data,
    input  logic                  q_valid,
    output logic                  q_ready,
    input  logic                  q_eop,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic                  r_eop,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_case_en,
    output logic                  wr_ctrl_en,
    output logic                  eng_start,
    input  logic                  eng_done,
    output logic                  busy,
    output logic                  irq,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_case_lim;
    logic [ADDR_WIDTH-1:0] r_ctrl_lim;
    logic [ADDR_WIDTH-1:0] r_case_cnt;
    logic [ADDR_WIDTH-1:0] r_ctrl_cnt;
    logic                  r_prio_ctrl;   // 0: case stream has priority, 1: control
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_wr_case_en;
    logic                  r_wr_ctrl_en;
    logic                  r_irq;
    logic                  r_err;

    logic w_in_load;
    logic w_case_complete;
    logic w_ctrl_complete;
    logic w_q_ready;
    logic w_r_ready;
    logic w_q_xfer;
    logic w_r_xfer;
    logic w_go_acc;
    logic w_irq_set;

    assign w_in_load       = (r_state == S_LOAD);
    assign w_case_complete = (r_case_cnt == r_case_lim);
    assign w_ctrl_complete = (r_ctrl_cnt == r_ctrl_lim);

    // Priority stream gets the slot; a stream that is already complete
    // hands the slot to the other one so it never stalls.
    assign w_q_ready = w_in_load & ~w_case_complete & (~r_prio_ctrl | w_ctrl_complete);
    assign w_r_ready = w_in_load & ~w_ctrl_complete & ( r_prio_ctrl | w_case_complete);

    assign w_q_xfer = q_valid & w_q_ready;
    assign w_r_xfer = r_valid & w_r_ready;

    // go only counts from IDLE or DONE, and abort overrides it.
    assign w_go_acc  = go & ~abort & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_irq_set = (r_state == S_RUN) & eng_done & ~abort;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort returns to IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (go) w_state_next = S_LOAD;
            S_LOAD:   if (w_case_complete && w_ctrl_complete && !w_q_xfer && !w_r_xfer)
                          w_state_next = S_LAUNCH;
            S_LAUNCH: w_state_next = S_RUN;
            S_RUN:    if (eng_done) w_state_next = S_DONE;
            S_DONE:   if (go) w_state_next = S_LOAD;
            default:  w_state_next = S_IDLE;
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
        end
    end

    // Beat limits, per-stream counters and the alternating priority bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_case_lim  <= '0;
            r_ctrl_lim  <= '0;
            r_case_cnt  <= '0;
            r_ctrl_cnt  <= '0;
            r_prio_ctrl <= 1'b0;
        end else if (abort) begin
            r_case_cnt  <= '0;
            r_ctrl_cnt  <= '0;
            r_prio_ctrl <= 1'b0;
        end else if (w_go_acc) begin
            r_case_lim  <= case_beats;
            r_ctrl_lim  <= ctrl_beats;
            r_case_cnt  <= '0;
            r_ctrl_cnt  <= '0;
            r_prio_ctrl <= 1'b0;
        end else begin
            if (w_q_xfer) r_case_cnt <= r_case_cnt + ONE;
            if (w_r_xfer) r_ctrl_cnt <= r_ctrl_cnt + ONE;
            if (w_in_load && !w_case_complete && !w_ctrl_complete)
                r_prio_ctrl <= ~r_prio_ctrl;
        end
    end

    // Registered BRAM write port: one cycle after each transfer. Not gated by
    // abort, so a beat accepted in the abort cycle is still written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_data    <= '0;
            r_wr_addr    <= '0;
            r_wr_case_en <= 1'b0;
            r_wr_ctrl_en <= 1'b0;
        end else begin
            r_wr_case_en <= w_q_xfer;
            r_wr_ctrl_en <= w_r_xfer;
            if (w_q_xfer) begin
                r_wr_data <= q_data;
                r_wr_addr <= r_case_cnt;
            end else if (w_r_xfer) begin
                r_wr_data <= r_data;
                r_wr_addr <= r_ctrl_cnt;
            end
        end
    end

    // Sticky run-complete interrupt; a set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clear || w_go_acc) begin
            r_irq <= 1'b0;
        end
    end

`ifdef GEN_EOP_CHECK_EN
    logic w_case_last;
    logic w_ctrl_last;

    assign w_case_last = ((r_case_cnt + ONE) == r_case_lim);
    assign w_ctrl_last = ((r_ctrl_cnt + ONE) == r_ctrl_lim);

    // Sticky framing error: eop must be high exactly on a stream's last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_go_acc) begin
            r_err <= 1'b0;
        end else if ((w_q_xfer && (q_eop != w_case_last)) ||
                     (w_r_xfer && (r_eop != w_ctrl_last))) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_eop;

    assign w_unused_eop = q_eop | r_eop;
    assign r_err        = 1'b0;
`endif

    assign q_ready    = w_q_ready;
    assign r_ready    = w_r_ready;
    assign wr_data    = r_wr_data;
    assign wr_addr    = r_wr_addr;
    assign wr_case_en = r_wr_case_en;
    assign wr_ctrl_en = r_wr_ctrl_en;
    assign eng_start  = (r_state == S_LAUNCH);
    assign busy       = w_in_load | (r_state == S_LAUNCH) | (r_state == S_RUN);
    assign irq        = r_irq;
    assign err        = r_err;

endmodule

// File: tb/tb_geno_load_scheduler.sv
// Directed bench for geno_load_scheduler: alternating load, single-stream
// load, run/irq handling, abort, zero limits and (with GEN_EOP_CHECK_EN)
// the eop framing check.
module tb_geno_load_scheduler;

    localparam int DW = 512;
    localparam int AW = 16;
    localparam int EW = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          go, abort, irq_clear;
    logic [AW-1:0] case_beats, ctrl_beats;
    logic [DW-1:0] q_data, r_data;
    logic          q_valid, q_ready, q_eop;
    logic          r_valid, r_ready, r_eop;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_case_en, wr_ctrl_en;
    logic          eng_start, eng_done;
    logic          busy, irq, err;

    // Expected BRAM writes: {is_ctrl, addr, data}, in issue order.
    logic [EW-1:0] exp_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int go_cyc  = 0;
    int start_cyc = 0;
    int n_start = 0;
    int q_idx, r_idx, q_eop_at, r_eop_at;
    bit q_on, r_on;

    geno_load_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .abort      (abort),
        .irq_clear  (irq_clear),
        .case_beats (case_beats),
        .ctrl_beats (ctrl_beats),
        .q_data     (q_data),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_eop      (q_eop),
        .r_data     (r_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_eop      (r_eop),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .wr_case_en (wr_case_en),
        .wr_ctrl_en (wr_ctrl_en),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .busy       (busy),
        .irq        (irq),
        .err        (err)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Recognisable per-stream, per-beat data word.
    function automatic logic [DW-1:0] pat(input bit ctrl, input int idx);
        logic [DW-1:0] v;
        logic [15:0]   i16;
        i16 = idx[15:0];
        v = '0;
        v[511:496] = ctrl ? 16'hC7A1 : 16'hCA5E;
        v[271:256] = ~i16;
        v[15:0]    = i16;
        return v;
    endfunction

    task automatic push_w(input bit ctrl, input int addr);
        logic [15:0] a16;
        a16 = addr[15:0];
        exp_q.push_back({ctrl, a16, pat(ctrl, addr)});
    endtask

    task automatic drive_src();
        q_valid = q_on;
        q_data  = pat(1'b0, q_idx);
        q_eop   = (q_idx == q_eop_at);
        r_valid = r_on;
        r_data  = pat(1'b1, r_idx);
        r_eop   = (r_idx == r_eop_at);
    endtask

    // One clock: note transfers, advance sources, clear pulses, check writes.
    task automatic tick();
        bit qx, rx;
        logic [EW-1:0] e;
        qx = q_valid & q_ready;
        rx = r_valid & r_ready;
        @(posedge clk);
        #1;
        cyc++;
        go = 1'b0;
        abort = 1'b0;
        irq_clear = 1'b0;
        if (qx) q_idx++;
        if (rx) r_idx++;
        drive_src();
        chk("ready_excl", q_ready & r_ready, 0);
        if (wr_case_en || wr_ctrl_en) begin
            chk("wr_excl", wr_case_en & wr_ctrl_en, 0);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {wr_ctrl_en, wr_addr}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_beat", {wr_ctrl_en, wr_addr, wr_data}, e);
            end
        end
        if (eng_start) begin
            n_start++;
            start_cyc = cyc;
        end
    endtask

    task automatic start_go(input int cb, input int rb, input bit qo, input bit ro);
        case_beats = cb[AW-1:0];
        ctrl_beats = rb[AW-1:0];
        q_on = qo;
        r_on = ro;
        q_idx = 0;
        r_idx = 0;
        q_eop_at = cb - 1;
        r_eop_at = rb - 1;
        drive_src();
        go = 1'b1;
        go_cyc = cyc;
        n_start = 0;
    endtask

    task automatic wait_start(input string tag, input int lat);
        int budget;
        budget = 0;
        while (n_start == 0 && budget < 40) begin
            tick();
            budget++;
        end
        chk({tag, "_start_seen"}, n_start, 1);
        chk({tag, "_start_lat"}, start_cyc - go_cyc, lat);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    // From LAUNCH: engine finishes on the first RUN cycle, then clear irq.
    task automatic finish_run(input string tag);
        q_on = 1'b0;
        r_on = 1'b0;
        drive_src();
        eng_done = 1'b1;
        tick();
        tick();
        eng_done = 1'b0;
        chk({tag, "_irq"}, irq, 1);
        chk({tag, "_busy"}, busy, 0);
        irq_clear = 1'b1;
        tick();
        chk({tag, "_irq_clr"}, irq, 0);
    endtask

    initial begin
        reset = 1'b1;
        go = 1'b0; abort = 1'b0; irq_clear = 1'b0; eng_done = 1'b0;
        case_beats = '0; ctrl_beats = '0;
        q_on = 1'b0; r_on = 1'b0; q_idx = 0; r_idx = 0; q_eop_at = -1; r_eop_at = -1;
        drive_src();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", err, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_ready", {q_ready, r_ready}, 0);
        chk("rst_wr", {wr_case_en, wr_ctrl_en, wr_addr, wr_data}, 0);

        // 4/4, both streams always valid: strict case/ctrl alternation.
        start_go(4, 4, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push_w(1'b0, i);
            push_w(1'b1, i);
        end
        tick();
        chk("t1_c1_ready", {q_ready, r_ready}, 2'b10);
        tick();
        chk("t1_c2_ready", {q_ready, r_ready}, 2'b01);
        wait_start("t1", 10);
        chk("t1_busy_launch", busy, 1);
        chk("t1_err", err, 0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) chk("t1_start_pulse", eng_start, 0);
            if (i == 2) go = 1'b1;
        end
        chk("t1_run_busy", busy, 1);
        chk("t1_run_irq", irq, 0);
        chk("t1_go_ignored", n_start, 1);
        chk("t1_run_ready", {q_ready, r_ready}, 0);
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("t1_done_irq", irq, 1);
        chk("t1_done_busy", busy, 0);
        q_on = 1'b0; r_on = 1'b0; drive_src();
        tick();
        tick();
        chk("t1_irq_sticky", irq, 1);
        irq_clear = 1'b1;
        tick();
        chk("t1_irq_clear", irq, 0);

        // 3/0, only case valid: control done at once, case gets every slot.
        start_go(3, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push_w(1'b0, i);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_q_ready", {q_ready, r_ready}, 2'b10);
        end
        wait_start("t2", 5);
        tick();
        eng_done = 1'b1;
        irq_clear = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("t2_set_wins", irq, 1);

        // go from DONE clears irq; abort after 2 case beats, with a third
        // beat accepted in the abort cycle still written.
        start_go(4, 0, 1'b1, 1'b0);
        tick();
        chk("t3_go_clr_irq", irq, 0);
        chk("t3_busy", busy, 1);
        for (int i = 0; i < 3; i++) push_w(1'b0, i);
        tick();
        tick();
        chk("t3_two_beats", q_idx, 2);
        abort = 1'b1;
        tick();
        chk("t3_abort_busy", busy, 0);
        chk("t3_abort_ready", {q_ready, r_ready}, 0);
        q_on = 1'b0; drive_src();
        for (int i = 0; i < 4; i++) tick();
        chk("t3_no_start", n_start, 0);
        chk("t3_writes_left", exp_q.size(), 0);
        go = 1'b1;
        abort = 1'b1;
        tick();
        chk("t3_abort_wins", busy, 0);
        start_go(4, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_w(1'b0, i);
        wait_start("t3r", 6);
        finish_run("t3r");

        // Both limits zero: straight through LOAD, no writes.
        start_go(0, 0, 1'b1, 1'b1);
        tick();
        chk("t4_ready", {q_ready, r_ready}, 0);
        chk("t4_busy", busy, 1);
        wait_start("t4", 2);
        finish_run("t4");

        // eop on beat 2 of 4 (not the last): framing error, flow unaffected.
        start_go(4, 0, 1'b1, 1'b0);
        q_eop_at = 2;
        drive_src();
        for (int i = 0; i < 4; i++) push_w(1'b0, i);
        wait_start("t5", 6);
`ifdef GEN_EOP_CHECK_EN
        chk("t5_err", err, 1);
`else
        chk("t5_err", err, 0);
`endif
        finish_run("t5");
        start_go(0, 0, 1'b0, 1'b0);
        tick();
        chk("t5_err_clr", err, 0);
        wait_start("t6", 2);
        finish_run("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/geno_load_scheduler.md
Name: geno_load_scheduler

Overview:
- Sequences one epistasis run of the SNP-pair engine: load, launch, wait, interrupt.
- Two Avalon-ST genotype streams (case, control) share the engine's BRAM write side. The block arbitrates between them with a fixed alternating priority, so neither stream is dropped when both are valid.
- Counts beats per stream, then pulses the engine start, waits for engine done and raises an interrupt.
- Sits between the CSR/stream wrapper and the engine top.

Parameters:
- DATA_WIDTH, 512, width of stream and BRAM write data.
- ADDR_WIDTH, 16, width of BRAM write address and of the beat counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  one-cycle pulse, start a load-and-run sequence.
- abort  in  1  one-cycle pulse, return to IDLE.
- irq_clear  in  1  one-cycle pulse, clear irq.
- case_beats  in  ADDR_WIDTH  expected case beats; sampled on accepted go.
- ctrl_beats  in  ADDR_WIDTH  expected control beats; sampled on accepted go.
- q_data  in  DATA_WIDTH  case stream data.
- q_valid  in  1  case stream valid.
- q_ready  out  1  case stream ready.
- q_eop  in  1  case stream end of packet.
- r_data  in  DATA_WIDTH  control stream data.
- r_valid  in  1  control stream valid.
- r_ready  out  1  control stream ready.
- r_eop  in  1  control stream end of packet.
- wr_data  out  DATA_WIDTH  BRAM write data.
- wr_addr  out  ADDR_WIDTH  BRAM write address (0-based beat index).
- wr_case_en  out  1  write strobe, case BRAM.
- wr_ctrl_en  out  1  write strobe, control BRAM.
- eng_start  out  1  one-cycle engine start pulse.
- eng_done  in  1  engine done level.
- busy  out  1  high in LOAD, LAUNCH, RUN.
- irq  out  1  run-complete interrupt, sticky.
- err  out  1  framing error flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; prio = case.
- FSM states: IDLE, LOAD, LAUNCH, RUN, DONE.
  - IDLE: on go, latch beat limits, clear counters → LOAD.
  - DONE: go is also accepted here; it clears irq and enters LOAD.
  - go in LOAD, LAUNCH or RUN is ignored.
  - LOAD: exits when case_cnt == case_lim and ctrl_cnt == ctrl_lim and no write is pending → LAUNCH.
  - LAUNCH: eng_start = 1 for exactly one cycle → RUN.
  - RUN: on eng_done = 1 → DONE; irq set the same edge.
  - DONE: irq held until irq_clear or an accepted go.
- A stream is complete when its count equals its limit. A limit of 0 means complete immediately. Both limits 0: LOAD lasts 1 cycle, then LAUNCH.
- Ready generation:
  - Readies are functions of registered state only; never of valid.
  - q_ready = LOAD & !case_complete & (prio == case | ctrl_complete).
  - r_ready = LOAD & !ctrl_complete & (prio == ctrl | case_complete).
  - At most one ready is high per cycle.
  - prio toggles every LOAD cycle while both streams are incomplete; otherwise it holds.
- Transfer = valid & ready. On a transfer:
  - The next cycle drives wr_data = data, wr_addr = stream count before increment, and the matching wr_*_en = 1 for one cycle.
  - The stream count increments.
  - Write latency is 1 cycle; the write enables are mutually exclusive.
- No byte reordering; data passes through unchanged.
- abort, any state: next cycle IDLE, readies 0, counters 0, no eng_start. A write registered from a transfer in the abort cycle still issues. irq is unchanged.
- abort and go in the same cycle: abort wins.
- irq_clear and an eng_done-driven irq set in the same cycle: set wins.
- Counters never exceed their limits; extra valid beats are back-pressured (ready = 0).

Optional Feature:
- Macro GEN_EOP_CHECK_EN.
- Defined: err is set (sticky, cleared by go or reset) in either of these cases:
  - q_eop/r_eop is 1 on a transfer that is not the stream's last beat.
  - The eop is 0 on the last beat.
- Flow is unaffected.
- Undefined: eop inputs are ignored and err is tied to 0.

Test Plan:
- go with case_beats = 4, ctrl_beats = 4, both valid continuously → accepts alternate case/ctrl, starting with case. Writes hit addresses 0..3 on each BRAM, 8 write cycles in total. eng_start pulses once, 1 cycle after the last write.
- case_beats = 3, ctrl_beats = 0, only q_valid → ctrl complete at once; q_ready high continuously; case addresses 0, 1, 2 written; then LAUNCH.
- eng_done raised 10 cycles after eng_start → irq = 1, busy = 0. irq_clear → irq = 0. A go in RUN before done is ignored.
- abort mid-LOAD after 2 case beats → IDLE next cycle, readies 0, no eng_start. A new go with the same limits restarts writes at address 0.
- Both limits 0 → eng_start 2 cycles after go; no writes.
- GEN_EOP_CHECK_EN: case_beats = 4 with q_eop on beat 2 → err = 1; load still completes. Next go clears err.
